poly_unison_oscillator: RTL and testbench

- Parametrised successor to the single-voice oscillator.
- Runs VOICES unison voices from one frequency word, each detuned by a programmable spread, and sums them into one signed sample.
- Voices are time-multiplexed through one shared phase/waveform datapath on the fast system clock, triggered by a 48 kHz sample strobe.
- Output feeds the synth mixer/filter chain.

---
 rtl/poly_unison_oscillator.sv | 160 ++++++++++++++++
 tb/tb_poly_unison_oscillator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/poly_unison_oscillator.sv
// Unison oscillator: VOICES detuned voices time-multiplexed through one phase/waveform path, averaged into one sample.
// Optional build macro PHASE_SPREAD_EN starts the voices evenly spread in phase instead of coherent.
module poly_unison_oscillator #(
  parameter int VOICES    = 4,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 16,
  parameter int FREQ_W    = 20,
  parameter int INC_MUL   = 44739,
  parameter int INC_SHIFT = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic [FREQ_W-1:0]       freq,
  input  logic [1:0]              ctrl,
  input  logic [3:0]              detune,
  input  logic                    sync,
  output logic signed [OUT_W-1:0] wave,
  output logic                    wave_valid,
  output logic                    busy
);

  localparam int LOG2V = $clog2(VOICES);
  localparam int VW    = (VOICES > 1) ? LOG2V : 1;
  localparam int MIX_W = OUT_W + LOG2V;
  localparam int PW    = FREQ_W + 32;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic signed [OUT_W-1:0] SQ_AMP = {1'b0, {(OUT_W-1){1'b1}}};
`ifdef PHASE_SPREAD_EN
  localparam bit SPREAD = 1'b1;
`else
  localparam bit SPREAD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [VW-1:0]             v_q, v_d;
  logic [FREQ_W-1:0]         freq_q, freq_d;
  logic [1:0]                ctrl_q, ctrl_d;
  logic [3:0]                detune_q, detune_d;
  logic                      sync_q, sync_d;
  logic [ACC_W-1:0]          phase_q [VOICES];
  logic [ACC_W-1:0]          phase_d [VOICES];
  logic [15:0]               lfsr_q, lfsr_d;
  logic signed [MIX_W-1:0]   mix_q, mix_d;
  logic signed [OUT_W-1:0]   wave_q, wave_d;

  logic [ACC_W-1:0]          inc, dstep, inc_v, phase_new;
  logic [15:0]               lfsr_nxt;
  logic signed [OUT_W-1:0]   sample;
  logic signed [MIX_W-1:0]   mix_sum;

  function automatic logic [ACC_W-1:0] init_phase(input int v);
    return SPREAD ? ACC_W'(64'(v) << (ACC_W - LOG2V)) : '0;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
  endfunction

  function automatic logic signed [OUT_W-1:0] voice_sample(input logic [ACC_W-1:0] ph,
                                                           input logic [1:0] c,
                                                           input logic [15:0] lf);
    logic [OUT_W-1:0] u, t;
    logic m;
    m = ph[ACC_W-1];
    u = ph[ACC_W-1 -: OUT_W];
    t = ph[ACC_W-2 -: OUT_W];
    if (m) t = ~t;
    case (c)
      2'b00:   return {~u[OUT_W-1], u[OUT_W-2:0]};
      2'b01:   return m ? -SQ_AMP : SQ_AMP;
      2'b10:   return {~t[OUT_W-1], t[OUT_W-2:0]};
      default: return OUT_W'($signed(lf));
    endcase
  endfunction

  // Shared voice datapath: increment for voice v_q, its updated phase and sample
  always_comb begin
    inc       = ACC_W'((PW'(freq_q) * PW'(INC_MUL)) >> INC_SHIFT);
    dstep     = ACC_W'(((ACC_W+4)'(inc) * (ACC_W+4)'(detune_q)) >> 10);
    inc_v     = inc + ACC_W'(v_q) * dstep;
    phase_new = (sync_q ? init_phase(int'(v_q)) : phase_q[v_q]) + inc_v;
    lfsr_nxt  = lfsr_step(lfsr_q);
    sample    = voice_sample(phase_new, ctrl_q, lfsr_nxt);
    mix_sum   = mix_q + MIX_W'(sample);
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    freq_d   = freq_q;
    ctrl_d   = ctrl_q;
    detune_d = detune_q;
    sync_d   = sync_q;
    phase_d  = phase_q;
    lfsr_d   = lfsr_q;
    mix_d    = mix_q;
    wave_d   = wave_q;
    case (state_q)
      IDLE: begin
        if (sample_en) begin
          state_d  = RUN;
          v_d      = '0;
          freq_d   = freq;
          ctrl_d   = ctrl;
          detune_d = detune;
          sync_d   = sync;
          mix_d    = '0;
        end
      end
      RUN: begin
        phase_d[v_q] = phase_new;
        if (ctrl_q == 2'b11) lfsr_d = lfsr_nxt;
        mix_d = mix_sum;
        if (v_q == VW'(VOICES - 1)) begin
          state_d = DONE;
          // Final voice folds straight into the output so wave is current while DONE flags it
          wave_d  = OUT_W'(mix_sum >>> LOG2V);
        end else begin
          v_d = v_q + VW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      v_q      <= '0;
      freq_q   <= '0;
      ctrl_q   <= '0;
      detune_q <= '0;
      sync_q   <= 1'b0;
      for (int i = 0; i < VOICES; i++) phase_q[i] <= init_phase(i);
      lfsr_q   <= LFSR_SEED;
      mix_q    <= '0;
      wave_q   <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      freq_q   <= freq_d;
      ctrl_q   <= ctrl_d;
      detune_q <= detune_d;
      sync_q   <= sync_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
      mix_q    <= mix_d;
      wave_q   <= wave_d;
    end
  end

  assign wave       = wave_q;
  assign wave_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_poly_unison_oscillator.sv
// Self-checking bench for poly_unison_oscillator against an arithmetic reference of the voice/mix rules.
module tb_poly_unison_oscillator;

  localparam int  NV   = 4;
  localparam longint ACC_MOD = 64'd1 << 24;
  localparam longint HALF    = 64'd1 << 23;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_en;
  logic [19:0]        freq;
  logic [1:0]         ctrl;
  logic [3:0]         detune;
  logic               sync;
  logic signed [15:0] wave;
  logic               wave_valid;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  longint     ph [NV];
  logic [15:0] lf;
  longint     exp_wave;

  poly_unison_oscillator #(
    .VOICES(NV), .ACC_W(24), .OUT_W(16), .FREQ_W(20), .INC_MUL(44739), .INC_SHIFT(12)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .freq(freq), .ctrl(ctrl),
    .detune(detune), .sync(sync), .wave(wave), .wave_valid(wave_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint init_of(input int v);
`ifdef PHASE_SPREAD_EN
    return longint'(v) * (ACC_MOD / NV);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) ph[v] = init_of(v);
    lf = 16'hACE1;
  endtask

  task automatic model_voice(input longint p, input logic [1:0] c, output longint s);
    longint t;
    case (c)
      2'd0: s = p / 256 - 32768;
      2'd1: s = (p >= HALF) ? -32767 : 32767;
      2'd2: begin
        t = (p / 128) % 65536;
        if (p >= HALF) t = 65535 - t;
        s = t - 32768;
      end
      default: begin
        lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        s = (lf >= 16'd32768) ? longint'(lf) - 65536 : longint'(lf);
      end
    endcase
  endtask

  task automatic model_sample(input logic [19:0] f, input logic [1:0] c, input logic [3:0] dt, input logic s);
    longint inc, d, sum, smp;
    inc = ((longint'(f) * 44739) / 4096) % ACC_MOD;
    d   = (inc * longint'(dt)) / 1024;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      ph[v] = ((s ? init_of(v) : ph[v]) + inc + longint'(v) * d) % ACC_MOD;
      model_voice(ph[v], c, smp);
      sum += smp;
    end
    exp_wave = (sum >= 0) ? sum / NV : -((-sum + NV - 1) / NV);
  endtask

  task automatic do_sample(input logic [19:0] f, input logic [1:0] c, input logic [3:0] dt, input logic s);
    int n;
    bit got;
    @(negedge clk);
    freq = f; ctrl = c; detune = dt; sync = s; sample_en = 1'b1;
    model_sample(f, c, dt, s);
    @(posedge clk); #1;
    sample_en = 1'b0;
    freq = 20'($urandom); ctrl = 2'($urandom); detune = 4'($urandom); sync = 1'($urandom);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (wave_valid) got = 1;
    end
    check("latency", n, 5);
    check("wave", wave, exp_wave);
    @(negedge clk);
    check("valid_one_cycle", wave_valid, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    int busy_cnt, valid_cnt;
    reset = 1'b0; sample_en = 1'b0; freq = '0; ctrl = '0; detune = '0; sync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", wave, 0);
    check("rst_valid", wave_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) reset = 1'b1;

    do_sample(20'd0, 2'b00, 4'd0, 1'b0);
`ifdef PHASE_SPREAD_EN
    check("first_spread", wave, -8192);
`else
    check("first_zero", wave, -32768);
`endif

    // Saw at 440 Hz from zero phase
    do_sample(20'd14080, 2'b00, 4'd0, 1'b0);
`ifndef PHASE_SPREAD_EN
    check("saw_first", wave, -32168);
`endif

    // Sync restarts all phases, with detune spreading the voices
    do_sample(20'd14080, 2'b00, 4'd5, 1'b1);
`ifndef PHASE_SPREAD_EN
    check("detune_sync", wave, -32164);
    check("detune_ph3", ph[3], 156040);
`endif

    // Three back-to-back strobes: only the first is taken
    @(negedge clk);
    freq = 20'd14080; ctrl = 2'b00; detune = 4'd0; sync = 1'b0; sample_en = 1'b1;
    model_sample(20'd14080, 2'b00, 4'd0, 1'b0);
    busy_cnt = 0; valid_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 2) sample_en = 1'b0;
      if (busy) busy_cnt++;
      if (wave_valid) valid_cnt++;
    end
    check("collide_busy", busy_cnt, 5);
    check("collide_valid", valid_cnt, 1);
    check("collide_wave", wave, exp_wave);

    // Square run across several half-periods
    for (int i = 0; i < 130; i++) begin
      do_sample(20'd14080, 2'b01, 4'd0, 1'b0);
      check("square_level", (wave == 16'sd32767 || wave == -16'sd32767), 1);
    end

    // Randomised pitch, waveform, detune and occasional sync
    for (int i = 0; i < 250; i++)
      do_sample(20'($urandom), 2'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));

    // Reset during RUN aborts the sample
    @(negedge clk);
    freq = 20'd30000; ctrl = 2'b10; detune = 4'd3; sync = 1'b0; sample_en = 1'b1;
    @(posedge clk); #1 sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_valid", wave_valid, 0);
    @(negedge clk) reset = 1'b1;
    valid_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wave_valid) valid_cnt++;
    end
    check("midrst_novalid", valid_cnt, 0);

    for (int i = 0; i < 20; i++)
      do_sample(20'($urandom), 2'($urandom), 4'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
